// File: rtl/tran_packer.sv
// tran_packer: packs variable-size unit chunks into fixed-width output words with backpressure and frame flush
module tran_packer #(
  parameter int UNIT_W = 4,
  parameter int IN_UNITS = 2,
  parameter int OUT_UNITS = 2,
  parameter int FLUSH_EN = 1,
  parameter logic [UNIT_W-1:0] PAD_VAL = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(IN_UNITS+1)-1:0]          in_units,
  input  logic [IN_UNITS*UNIT_W-1:0]             data_in,
  output logic [OUT_UNITS*UNIT_W-1:0]            data_o,
  output logic                                   data_en,
  input  logic                                   out_ready,
  output logic [$clog2(OUT_UNITS+1)-1:0]         data_units,
  output logic                                   data_last,
  output logic                                   err
);
  localparam int ACC_UNITS = OUT_UNITS + IN_UNITS - 1;
  localparam int IN_W = IN_UNITS * UNIT_W;
  localparam int OUT_W = OUT_UNITS * UNIT_W;
  localparam int ACC_W = ACC_UNITS * UNIT_W;
  localparam int IU_W = $clog2(IN_UNITS + 1);
  localparam int OU_W = $clog2(OUT_UNITS + 1);
  localparam int CW = $clog2(ACC_UNITS + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sh, ins;
  logic [CW-1:0] cnt_q, cnt_d, cnt_ae;
  logic [OUT_W-1:0] data_q, word;
  logic [IN_W-1:0] in_mask;
  logic [OU_W-1:0] units_q;
  logic en_q, last_q, err_q;
  logic ending, full, flush_partial, emit, legal, take, bad, drop;
  assign data_o = data_q;
  assign data_en = en_q;
  assign data_units = units_q;
  assign data_last = last_q;
  assign err = err_q;
  // Emit/accept decision, accumulator shift-and-append, and the padded output word
  always_comb begin
    ending = state_q == FLUSH || (state_q == RUN && !start && FLUSH_EN != 0);
    full = cnt_q >= CW'(OUT_UNITS);
    flush_partial = ending && cnt_q != '0 && !full;
    emit = (full || flush_partial) && (!en_q || out_ready);
    cnt_ae = emit ? (full ? cnt_q - CW'(OUT_UNITS) : '0) : cnt_q;
    in_ready = start && state_q != FLUSH && cnt_ae < CW'(OUT_UNITS);
    legal = in_units != '0 && in_units <= IU_W'(IN_UNITS);
    take = in_valid && in_ready && legal;
    bad = in_valid && in_ready && !legal;
    drop = state_q == RUN && !start && FLUSH_EN == 0;
    in_mask = ~({IN_W{1'b1}} << (int'(in_units) * UNIT_W));
    acc_sh = emit ? acc_q >> OUT_W : acc_q;
    ins = ACC_W'(data_in & in_mask) << (int'(cnt_ae) * UNIT_W);
    acc_d = drop ? '0 : (take ? acc_sh | ins : acc_sh);
    cnt_d = drop ? '0 : cnt_ae + (take ? CW'(in_units) : '0);
    word = acc_q[OUT_W-1:0];
    for (int i = 0; i < OUT_UNITS; i++)
      word[i*UNIT_W +: UNIT_W] = (flush_partial && i >= int'(cnt_q)) ? PAD_VAL : acc_q[i*UNIT_W +: UNIT_W];
  end
  // Frame FSM, accumulator state and registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      en_q <= 1'b0;
      units_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_q == IDLE ? (start ? RUN : IDLE)
               : state_q == RUN ? (start ? RUN : (cnt_ae == '0 || FLUSH_EN == 0) ? IDLE : FLUSH)
               : (cnt_ae == '0 ? IDLE : FLUSH);
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_q || bad;
      if (emit) begin
        data_q <= word;
        en_q <= 1'b1;
        units_q <= flush_partial ? OU_W'(cnt_q) : OU_W'(OUT_UNITS);
        last_q <= ending && cnt_q <= CW'(OUT_UNITS);
      end else if (en_q && out_ready) begin
        en_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tran_packer.sv
// tb_tran_packer: directed checks of packing, backpressure, flush, error and reset behaviour
module tb_tran_packer;
  logic clk = 1'b0, reset, start, in_valid, out_ready;
  logic [1:0] in_units;
  logic [7:0] data_in;
  logic in_ready, data_en, data_last, err;
  logic [7:0] data_o;
  logic [1:0] data_units;
  logic n_in_ready, n_en, n_last, n_err;
  logic [7:0] n_data;
  logic [1:0] n_units;
  int n_tot = 0, n_bad = 0;
  always #5 clk = ~clk;
  tran_packer dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_units(in_units), .data_in(data_in), .data_o(data_o), .data_en(data_en),
    .out_ready(out_ready), .data_units(data_units), .data_last(data_last), .err(err)
  );
  tran_packer #(.FLUSH_EN(0)) dut_nf (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_units(in_units), .data_in(data_in), .data_o(n_data), .data_en(n_en),
    .out_ready(out_ready), .data_units(n_units), .data_last(n_last), .err(n_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [1:0] u, input logic [7:0] d);
    in_valid = 1'b1;
    in_units = u;
    data_in = d;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_units = '0; data_in = '0;
    tick; tick;
    check("rst_data", data_o, 8'h00);
    check("rst_en", data_en, 0);
    check("rst_units", data_units, 0);
    check("rst_last", data_last, 0);
    check("rst_err", err, 0);
    check("rst_rdy", in_ready, 0);
    reset = 1'b0;
    start = 1'b1; beat(2, 8'hA5);
    #1 check("t1_rdy0", in_ready, 1);
    tick;
    check("t1_en0", data_en, 0);
    data_in = 8'h3C;
    #1 check("t1_rdy1", in_ready, 1);
    tick;
    check("t1_w0", data_o, 8'hA5);
    check("t1_en1", data_en, 1);
    check("t1_u0", data_units, 2);
    check("t1_l0", data_last, 0);
    in_valid = 1'b0;
    tick;
    check("t1_w1", data_o, 8'h3C);
    check("t1_en2", data_en, 1);
    tick;
    check("t1_en3", data_en, 0);
    beat(1, 8'h67);
    tick;
    check("t2_en0", data_en, 0);
    data_in = 8'h49;
    tick;
    in_valid = 1'b0;
    tick;
    check("t2_w", data_o, 8'h97);
    check("t2_en", data_en, 1);
    check("t2_u", data_units, 2);
    tick;
    check("t2_en1", data_en, 0);
    beat(1, 8'hC1);
    tick;
    beat(2, 8'hBA);
    tick;
    in_valid = 1'b0; start = 1'b0;
    tick;
    check("t3_w0", data_o, 8'hA1);
    check("t3_l0", data_last, 0);
    check("t3_u0", data_units, 2);
    check("t3_nf_w0", n_data, 8'hA1);
    tick;
    check("t3_w1", data_o, 8'h0B);
    check("t3_u1", data_units, 1);
    check("t3_l1", data_last, 1);
    check("t3_en1", data_en, 1);
    check("t3_nf_en", n_en, 0);
    tick;
    check("t3_en2", data_en, 0);
    check("t3_rdy_idle", in_ready, 0);
    start = 1'b1;
    #1 check("t3_rdy_start", in_ready, 1);
    beat(2, 8'hA5);
    tick;
    data_in = 8'h22;
    tick;
    check("t4_w0", data_o, 8'hA5);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check("t4_rdy_full", in_ready, 0);
    tick;
    check("t4_hold", data_o, 8'hA5);
    check("t4_hold_en", data_en, 1);
    tick;
    check("t4_hold2", data_o, 8'hA5);
    out_ready = 1'b1;
    #1 check("t4_rdy_go", in_ready, 1);
    tick;
    check("t4_w1", data_o, 8'h22);
    check("t4_en1", data_en, 1);
    tick;
    check("t4_en2", data_en, 0);
    beat(0, 8'hFF);
    tick;
    check("t5_err0", err, 1);
    check("t5_en0", data_en, 0);
    in_units = 2'd3;
    tick;
    check("t5_err1", err, 1);
    check("t5_en1", data_en, 0);
    beat(1, 8'h05);
    tick;
    data_in = 8'h06;
    tick;
    in_valid = 1'b0;
    tick;
    check("t5_w", data_o, 8'h65);
    check("t5_err2", err, 1);
    tick;
    beat(1, 8'h03);
    tick;
    in_valid = 1'b0; reset = 1'b1;
    tick;
    check("t6_data", data_o, 8'h00);
    check("t6_en", data_en, 0);
    check("t6_units", data_units, 0);
    check("t6_last", data_last, 0);
    check("t6_err", err, 0);
    reset = 1'b0; start = 1'b0;
    tick;
    check("t6_noflush0", data_en, 0);
    tick;
    check("t6_noflush1", data_en, 0);
    start = 1'b1; beat(1, 8'h04);
    tick;
    in_valid = 1'b0; start = 1'b0;
    tick;
    check("t7_w", data_o, 8'h04);
    check("t7_u", data_units, 1);
    check("t7_l", data_last, 1);
    check("t7_nf_en0", n_en, 0);
    tick;
    check("t7_nf_en1", n_en, 0);
    check("t7_en", data_en, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
